// File: rtl/quantum_scheduler.sv
// rtl/quantum_scheduler.sv - round-robin quantum preemption and dispatch unit
//
// Ports:
//   clk, rst_n                 clock, asynchronous active-low reset
//   instr_valid, pc, opcode    retiring instruction from fetch/decode
//   io_req, proc_done          I/O block / exit of the running process
//   proc_start, start_id       load a new process into a FREE slot
//   io_done, io_done_id        I/O completion for a BLOCKED slot
//   ctx_ack                    OS finished the context switch
//   ctx_switch, cause          switch request (held until ack) and its reason
//   saved_pc, saved_id         resume PC and slot of the outgoing process
//   next_id, next_valid        incoming slot and whether it is runnable
//   cur_id, idle               running slot, no process running
module quantum_scheduler #(
    parameter int         NPROC    = 4,
    parameter int         QUANTUM  = 5,
    parameter int         PC_W     = 32,
    parameter int         OS_LIMIT = 300,
    parameter logic [5:0] OP_JUMP  = 6'b010001,
    parameter logic [5:0] OP_JUMPR = 6'b010010,
    parameter logic [5:0] OP_BEQ   = 6'b010100,
    parameter logic [5:0] OP_IN    = 6'b011101,
    parameter logic [5:0] OP_OUT   = 6'b011110,
    localparam int        IDW      = $clog2(NPROC)
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            instr_valid,
    input  logic [PC_W-1:0] pc,
    input  logic [5:0]      opcode,
    input  logic            io_req,
    input  logic            proc_done,
    input  logic            proc_start,
    input  logic [IDW-1:0]  start_id,
    input  logic            io_done,
    input  logic [IDW-1:0]  io_done_id,
    input  logic            ctx_ack,
    output logic            ctx_switch,
    output logic [1:0]      cause,
    output logic [PC_W-1:0] saved_pc,
    output logic [IDW-1:0]  saved_id,
    output logic [IDW-1:0]  next_id,
    output logic [IDW-1:0]  cur_id,
    output logic            next_valid,
    output logic            idle
);

    localparam int CW = $clog2(QUANTUM + 1);

    typedef enum logic [1:0] {S_FREE, S_READY, S_RUNNING, S_BLOCKED} slot_t;
    typedef enum logic [1:0] {ST_IDLE, ST_RUN, ST_SWITCH} fsm_t;

    slot_t         slot_q  [NPROC];
    slot_t         slot_nx [NPROC];
    fsm_t          state_q, state_nx;
    logic [CW-1:0] cnt_q;

    logic          counted;
    logic          ev_any;
    logic [1:0]    ev_cause;
    logic          sel_valid;
    logic [IDW-1:0] sel_id;

    always_comb begin
        counted = instr_valid && (pc > PC_W'(OS_LIMIT)) &&
                  !(opcode inside {OP_JUMP, OP_JUMPR, OP_BEQ, OP_IN, OP_OUT});
        ev_any  = (state_q == ST_RUN) && counted &&
                  (proc_done || io_req || (cnt_q >= CW'(QUANTUM - 1)));
        if (proc_done)   ev_cause = 2'b10;
        else if (io_req) ev_cause = 2'b01;
        else             ev_cause = 2'b00;
    end

    // Slot table after this cycle's updates. io_done is applied before the
    // event so a same-slot io_done + io_req leaves the slot BLOCKED.
    always_comb begin
        for (int i = 0; i < NPROC; i++) slot_nx[i] = slot_q[i];
        if (io_done && int'(io_done_id) < NPROC && slot_q[io_done_id] == S_BLOCKED)
            slot_nx[io_done_id] = S_READY;
        if (proc_start && int'(start_id) < NPROC && slot_q[start_id] == S_FREE)
            slot_nx[start_id] = S_READY;
        if (ev_any) begin
            case (ev_cause)
                2'b10:   slot_nx[cur_id] = S_FREE;
                2'b01:   slot_nx[cur_id] = S_BLOCKED;
                default: slot_nx[cur_id] = S_READY;
            endcase
        end
        if (state_q == ST_SWITCH && ctx_ack && next_valid)
            slot_nx[next_id] = S_RUNNING;
    end

    // Round-robin search starting after cur_id; k == NPROC lands on cur_id
    // itself, so the outgoing slot is the last candidate.
    always_comb begin
        int idx;
        sel_valid = 1'b0;
        sel_id    = '0;
        idx       = 0;
        for (int k = 1; k <= NPROC; k++) begin
            idx = (int'(cur_id) + k) % NPROC;
            if (!sel_valid && slot_nx[idx] == S_READY) begin
                sel_valid = 1'b1;
                sel_id    = IDW'(idx);
            end
        end
    end

    always_comb begin
        state_nx = state_q;
        case (state_q)
            ST_IDLE:   if (sel_valid) state_nx = ST_SWITCH;
            ST_RUN:    if (ev_any)    state_nx = ST_SWITCH;
            ST_SWITCH: if (ctx_ack)   state_nx = next_valid ? ST_RUN : ST_IDLE;
            default:   state_nx = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= ST_IDLE;
            for (int i = 0; i < NPROC; i++) slot_q[i] <= S_FREE;
            cnt_q      <= '0;
            ctx_switch <= 1'b0;
            cause      <= 2'b00;
            saved_pc   <= '0;
            saved_id   <= '0;
            next_id    <= '0;
            cur_id     <= '0;
            next_valid <= 1'b0;
            idle       <= 1'b1;
        end else begin
            state_q <= state_nx;
            for (int i = 0; i < NPROC; i++) slot_q[i] <= slot_nx[i];
            case (state_q)
                ST_IDLE: begin
                    if (sel_valid) begin
                        cause      <= 2'b11;
                        saved_pc   <= '0;
                        saved_id   <= cur_id;
                        next_id    <= sel_id;
                        next_valid <= 1'b1;
                        ctx_switch <= 1'b1;
                    end
                end
                ST_RUN: begin
                    if (ev_any) begin
                        saved_pc   <= pc + PC_W'(1);
                        saved_id   <= cur_id;
                        cause      <= ev_cause;
                        cnt_q      <= '0;
                        next_id    <= sel_id;
                        next_valid <= sel_valid;
                        ctx_switch <= 1'b1;
                    end else if (counted && cnt_q != CW'(QUANTUM)) begin
                        cnt_q <= cnt_q + CW'(1);
                    end
                end
                ST_SWITCH: begin
                    if (ctx_ack) begin
                        ctx_switch <= 1'b0;
                        cnt_q      <= '0;
                        if (next_valid) begin
                            cur_id <= next_id;
                            idle   <= 1'b0;
                        end else begin
                            idle   <= 1'b1;
                        end
                    end else begin
                        next_id    <= sel_id;
                        next_valid <= sel_valid;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_quantum_scheduler.sv
// tb/tb_quantum_scheduler.sv - scoreboard bench for quantum_scheduler
module tb_quantum_scheduler;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        instr_valid, io_req, proc_done, proc_start, io_done, ctx_ack;
    logic [31:0] pc;
    logic [5:0]  opcode;
    logic [1:0]  start_id, io_done_id;
    logic        ctx_switch, next_valid, idle;
    logic [1:0]  cause, saved_id, next_id, cur_id;
    logic [31:0] saved_pc;

    localparam logic [5:0] OP_ADD = 6'b000001;
    localparam logic [5:0] OP_BEQ = 6'b010100;

    quantum_scheduler dut (
        .clk(clk), .rst_n(rst_n), .instr_valid(instr_valid), .pc(pc), .opcode(opcode),
        .io_req(io_req), .proc_done(proc_done), .proc_start(proc_start), .start_id(start_id),
        .io_done(io_done), .io_done_id(io_done_id), .ctx_ack(ctx_ack),
        .ctx_switch(ctx_switch), .cause(cause), .saved_pc(saved_pc), .saved_id(saved_id),
        .next_id(next_id), .cur_id(cur_id), .next_valid(next_valid), .idle(idle)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [1:0]  cause;
        logic [31:0] spc;
        logic [1:0]  sid;
        logic [1:0]  nid;
        logic        nv;
        bit          chk_nid;
    } exp_t;

    exp_t exp_q[$];
    int   errs   = 0;
    int   checks = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errs++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic push(input logic [1:0] c, input logic [31:0] spc, input logic [1:0] sid,
                        input logic [1:0] nid, input logic nv, input bit cn);
        exp_t e;
        e.cause = c; e.spc = spc; e.sid = sid; e.nid = nid; e.nv = nv; e.chk_nid = cn;
        exp_q.push_back(e);
    endtask

    // Monitor: every rising ctx_switch must match the oldest expectation.
    logic sw_d = 1'b0;
    always @(negedge clk) begin
        if (ctx_switch && !sw_d) begin
            if (exp_q.size() == 0) begin
                chk("unexpected_switch", 32'(cause), 32'hFFFF_FFFF);
            end else begin
                exp_t e;
                e = exp_q.pop_front();
                chk("cause", 32'(cause), 32'(e.cause));
                chk("saved_pc", saved_pc, e.spc);
                chk("saved_id", 32'(saved_id), 32'(e.sid));
                chk("next_valid", 32'(next_valid), 32'(e.nv));
                if (e.chk_nid) chk("next_id", 32'(next_id), 32'(e.nid));
            end
        end
        sw_d = ctx_switch;
    end

    task automatic cyc();
        @(posedge clk); #1;
    endtask

    task automatic issue(input logic [31:0] p, input logic [5:0] op, input logic io, input logic dn);
        instr_valid = 1'b1; pc = p; opcode = op; io_req = io; proc_done = dn;
        cyc();
        instr_valid = 1'b0; io_req = 1'b0; proc_done = 1'b0;
    endtask

    task automatic run_quantum(input logic [31:0] base);
        for (int i = 0; i < 5; i++) issue(base + 32'(i), OP_ADD, 1'b0, 1'b0);
    endtask

    task automatic start(input logic [1:0] id);
        proc_start = 1'b1; start_id = id;
        cyc();
        proc_start = 1'b0;
    endtask

    task automatic wait_switch();
        for (int i = 0; i < 20 && !ctx_switch; i++) cyc();
        chk("switch_seen", 32'(ctx_switch), 32'd1);
    endtask

    task automatic ack();
        ctx_ack = 1'b1;
        cyc();
        ctx_ack = 1'b0;
    endtask

    initial begin
        rst_n = 1'b0;
        instr_valid = 0; io_req = 0; proc_done = 0; proc_start = 0; io_done = 0; ctx_ack = 0;
        pc = '0; opcode = '0; start_id = '0; io_done_id = '0;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_ctx_switch", 32'(ctx_switch), 0);
        chk("rst_cause", 32'(cause), 0);
        chk("rst_saved_pc", saved_pc, 0);
        chk("rst_saved_id", 32'(saved_id), 0);
        chk("rst_next_id", 32'(next_id), 0);
        chk("rst_cur_id", 32'(cur_id), 0);
        chk("rst_next_valid", 32'(next_valid), 0);
        chk("rst_idle", 32'(idle), 1);
        rst_n = 1'b1;
        cyc();

        // Dispatch from idle: only slot 0 ready.
        push(2'b11, 32'd0, 2'd0, 2'd0, 1'b1, 1'b1);
        start(2'd0);
        wait_switch();
        ack();
        chk("disp_cur_id", 32'(cur_id), 0);
        chk("disp_idle", 32'(idle), 0);
        start(2'd1);

        // Quantum with excluded instructions interleaved.
        issue(32'd301, OP_ADD, 0, 0);
        issue(32'd200, OP_ADD, 0, 0);
        issue(32'd302, OP_ADD, 0, 0);
        issue(32'd400, OP_BEQ, 0, 0);
        issue(32'd303, OP_ADD, 0, 0);
        issue(32'd250, OP_ADD, 0, 0);
        issue(32'd304, OP_ADD, 0, 0);
        chk("no_early_switch", 32'(ctx_switch), 0);
        push(2'b00, 32'd306, 2'd0, 2'd1, 1'b1, 1'b1);
        issue(32'd305, OP_ADD, 0, 0);
        wait_switch();
        ack();
        chk("q_cur_id", 32'(cur_id), 1);

        // I/O block on slot 1.
        push(2'b01, 32'd501, 2'd1, 2'd0, 1'b1, 1'b1);
        issue(32'd500, OP_ADD, 1, 0);
        wait_switch();
        ack();
        chk("io_cur_id", 32'(cur_id), 0);

        // Slot 1 blocked: slot 0 re-selected on its own quantum.
        push(2'b00, 32'd605, 2'd0, 2'd0, 1'b1, 1'b1);
        run_quantum(32'd600);
        wait_switch();
        ack();
        chk("blk_cur_id", 32'(cur_id), 0);

        // Wake slot 1 and start slot 3 in the same cycle.
        io_done = 1'b1; io_done_id = 2'd1; proc_start = 1'b1; start_id = 2'd3;
        cyc();
        io_done = 1'b0; proc_start = 1'b0;
        push(2'b00, 32'd705, 2'd0, 2'd1, 1'b1, 1'b1);
        run_quantum(32'd700);
        wait_switch();
        ack();
        chk("wake_cur_id", 32'(cur_id), 1);

        // Priority: exit + io + quantum on the same instruction.
        for (int i = 0; i < 4; i++) issue(32'd800 + 32'(i), OP_ADD, 0, 0);
        push(2'b10, 32'd805, 2'd1, 2'd3, 1'b1, 1'b1);
        issue(32'd804, OP_ADD, 1, 1);
        wait_switch();
        ack();
        chk("prio_cur_id", 32'(cur_id), 3);

        // Exit slot 3, then the last process 0; slot 1 must be FREE.
        push(2'b10, 32'd901, 2'd3, 2'd0, 1'b1, 1'b1);
        issue(32'd900, OP_ADD, 0, 1);
        wait_switch();
        ack();
        chk("exit_cur_id", 32'(cur_id), 0);
        push(2'b10, 32'd1001, 2'd0, 2'd0, 1'b0, 1'b0);
        issue(32'd1000, OP_ADD, 0, 1);
        wait_switch();
        ack();
        chk("exit_idle", 32'(idle), 1);
        chk("exit_ctx_switch", 32'(ctx_switch), 0);

        // Dispatch from idle to slot 2, then reset mid-switch.
        push(2'b11, 32'd0, 2'd0, 2'd2, 1'b1, 1'b1);
        start(2'd2);
        wait_switch();
        @(negedge clk);
        #1;
        rst_n = 1'b0;
        #1;
        chk("mid_rst_ctx_switch", 32'(ctx_switch), 0);
        chk("mid_rst_cause", 32'(cause), 0);
        chk("mid_rst_saved_pc", saved_pc, 0);
        chk("mid_rst_next_id", 32'(next_id), 0);
        chk("mid_rst_next_valid", 32'(next_valid), 0);
        chk("mid_rst_idle", 32'(idle), 1);
        chk("queue_empty", 32'(exp_q.size()), 0);
        repeat (2) @(posedge clk);

        $display("Result: errors=%0d of %0d checks", errs, checks);
        $finish;
    end

endmodule

// File: doc/quantum_scheduler.md
# quantum_scheduler

Parametrised round-robin preemption and dispatch unit for the multiprogrammed processor: counts retired user-mode instructions per process, raises a context-switch request on quantum expiry, I/O request or process exit, and chooses the next process to run. It keeps a per-slot process state table, so the OS dispatcher only saves and restores context. It sits between the fetch/decode stage, which supplies PC and opcode, and the OS context-switch routine, which acknowledges each switch.

## Interface
- NPROC, 4: number of process slots (2..16); ids are $clog2(NPROC) bits wide.
- QUANTUM, 5: counted instructions per time slice (≥1).
- PC_W, 32: PC width.
- OS_LIMIT, 300: PCs ≤ OS_LIMIT are OS code and never counted.
- OP_JUMP/OP_JUMPR/OP_BEQ/OP_IN/OP_OUT, 6'b010001/6'b010010/6'b010100/6'b011101/6'b011110: opcodes excluded from counting.
- clock  in  1  system clock; all state updates on rising edge.
- reset  in  1  asynchronous, active-low reset.
- instr_valid  in  1  one instruction retires this cycle.
- pc  in  PC_W  PC of the retiring instruction.
- opcode  in  6  opcode of the retiring instruction.
- io_req  in  1  retiring instruction is an I/O instruction of the running process.
- proc_done  in  1  running process executes its exit.
- proc_start, start_id  in  1, ID  load a new process into slot start_id.
- io_done, io_done_id  in  1, ID  I/O for slot io_done_id has completed.
- ctx_ack  in  1  OS has finished the switch.
- ctx_switch  out  1  switch request; held until acknowledged.
- cause  out  2  00 quantum, 01 I/O, 10 exit, 11 dispatch from idle.
- saved_pc  out  PC_W  resume PC of the outgoing process (pc+1).
- saved_id, next_id, cur_id  out  ID  outgoing, incoming and running slot.
- next_valid  out  1  next_id holds a runnable process.
- idle  out  1  no process is running.

## Operation
- Slot states: FREE, READY, RUNNING, BLOCKED. Reset sets all slots to FREE.
- proc_start on a FREE slot sets it to READY. proc_start on any other slot is ignored.
- io_done on a BLOCKED slot sets it to READY. io_done on any other slot is ignored.
- Controller FSM has three states: IDLE, RUN, SWITCH.
- Counted instruction: instr_valid, pc > OS_LIMIT, and opcode not in the excluded set. Only counted instructions qualify for io_req and proc_done events.
- In RUN, each counted instruction increments the counter. Event priority is proc_done > io_req > quantum.
  - exit: the slot becomes FREE.
  - I/O: the slot becomes BLOCKED.
  - quantum: the slot becomes READY. The quantum event fires on the counted instruction that brings the counter to QUANTUM.
- On any event:
  - register saved_pc = pc+1, which wraps modulo 2^PC_W;
  - register saved_id = cur_id and cause;
  - clear the counter and enter SWITCH.
- Next selection is round-robin from cur_id+1 upward, wrapping, over READY slots, using the slot states after the event update. The outgoing slot is considered last, so a lone quantum-expired process is re-selected.
- If no slot is READY, next_valid = 0.
- In IDLE, when any slot is READY, compute next_id, set cause = 11 and saved_pc = 0, then enter SWITCH.
- In SWITCH:
  - ctx_switch = 1; instr_valid, io_req and proc_done are ignored.
  - proc_start and io_done are still applied to the slot table.
  - next_id and next_valid are recomputed every cycle until ack.
- On ctx_ack in SWITCH:
  - if next_valid, cur_id = next_id, that slot becomes RUNNING, and the FSM goes to RUN;
  - otherwise the FSM goes to IDLE with idle = 1.
- ctx_ack outside SWITCH is ignored.
- The counter width is $clog2(QUANTUM+1). The counter saturates and never wraps.

## Timing
- Reset state: ctx_switch = 0, cause = 00, saved_pc = 0, saved_id = 0, next_id = 0, cur_id = 0, next_valid = 0, idle = 1, counter = 0, FSM in IDLE.
- Event at edge N means ctx_switch is high after edge N, which is one cycle of latency.
- ctx_switch falls on the edge that samples ctx_ack = 1. RUN or IDLE is active from that edge.
- Minimum switch is 2 cycles, with ctx_ack high in the first SWITCH cycle.
- proc_start and io_done in the same cycle, on different slots, are both applied.
- io_done and io_req on the same slot in the same cycle: the slot ends BLOCKED, because the completion precedes the block.
- Reset asserted mid-switch clears everything immediately; no ack is required.

## Test plan
- Quantum: NPROC=4, QUANTUM=5, slots 0 and 1 started. Dispatch gives cur_id=0. Five counted instructions at pc=301..305 → ctx_switch, cause=00, saved_pc=306, saved_id=0, next_id=1.
- Exclusions: interleave pc=200 instructions and OP_BEQ at pc=400 among four counted instructions → no switch. The fifth counted instruction triggers the switch.
- I/O block/wake: io_req from slot 1 at pc=500 → cause=01, saved_pc=501. After ack, slot 1 is never selected until io_done(1), after which it is selected on the next switch.
- Exit and idle: the sole process issues proc_done → cause=10, next_valid=0. After ack, idle=1. proc_start(2) → cause=11, next_id=2.
- Priority: proc_done, io_req and quantum expiry on the same instruction → cause=10, and the slot becomes FREE.
- Reset mid-SWITCH: assert reset while ctx_switch=1 → all outputs return to reset values asynchronously.
